stdp_trace_q14: RTL and testbench

Upstream stage of the STDP weight-update engine. It maintains per-neuron eligibility traces in Q14: F presynaptic traces x[i] and N postsynaptic traces y[j]. On each timestep it decays every trace and bumps it on a spike, one trace per cycle. It exposes a registered read port so the weight-update engine can fetch x/y values between timesteps.

---
 rtl/stdp_pkg.sv | 19 +
 rtl/stdp_trace_q14_decay.sv | 32 +++
 rtl/stdp_trace_q14.sv | 156 +++++++++++++++
 tb/tb_stdp_trace_q14.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared types and constants for the STDP trace and weight-update engines.
package stdp_pkg;

  localparam int Q14_ONE   = 16384;
  localparam int TRACE_MAX = 32767;

  typedef logic signed [15:0] q14_t;

  typedef enum logic [1:0] {StIdle, StPre, StPost, StDone} trace_state_e;

  // Index width wide enough to address either trace bank.
  function automatic int unsigned max_idx_w(input int unsigned f, input int unsigned n);
    int unsigned m;
    m = (f > n) ? f : n;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/stdp_trace_q14_decay.sv
// Combinational Q14 trace update: floor(t*lambda) plus optional spike bump, clamped.
module trace_decay_q14
  import stdp_pkg::*;
#(
  parameter int unsigned Q = 14
) (
  input  q14_t t,
  input  q14_t lambda,
  input  q14_t b,
  input  logic spike,
  output q14_t result
);

  logic signed [31:0] p;
  logic signed [17:0] d;
  logic signed [17:0] s;

  assign p = 32'(t) * 32'(lambda);
  // Traces are non-negative, so the floored product always fits in 18 bits.
  assign d = 18'(p >>> Q);
  assign s = d + (spike ? 18'(b) : 18'sd0);

  always_comb begin
    result = s[15:0];
    if (s < 18'sd0) begin
      result = '0;
    end else if (s > 18'(TRACE_MAX)) begin
      result = 16'(TRACE_MAX);
    end
  end

endmodule

// File: rtl/stdp_trace_q14.sv
// Pre/post eligibility trace bank: one trace updated per cycle per timestep sweep.
module stdp_trace_q14
  import stdp_pkg::*;
#(
  parameter  int unsigned F  = 48,
  parameter  int unsigned N  = 96,
  parameter  int unsigned Q  = 14,
  localparam int unsigned IW = max_idx_w(F, N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_valid,
  output logic          step_ready,
  input  logic [F-1:0]  pre_bits,
  input  logic [N-1:0]  post_bits,
  input  q14_t          lambda_x,
  input  q14_t          lambda_y,
  input  q14_t          b_pre,
  input  q14_t          b_post,
  input  logic          clear,
  output logic          step_done,
  input  logic          rd_en,
  input  logic          rd_is_post,
  input  logic [IW-1:0] rd_idx,
  output q14_t          rd_data,
  output logic          rd_valid
);

  trace_state_e  state_q;
  logic [IW-1:0] idx_q;
  logic [F-1:0]  pre_q;
  logic [N-1:0]  post_q;
  q14_t          lx_q, ly_q, bpre_q, bpost_q;
  q14_t          x_q [F];
  q14_t          y_q [N];
  logic          step_done_q, rd_valid_q;
  q14_t          rd_data_q;

  q14_t cur_t, cur_lambda, cur_b, upd, rd_sel;
  logic cur_spike;
  logic last_pre, last_post, in_post;

  assign in_post    = (state_q == StPost);
  assign cur_lambda = in_post ? ly_q : lx_q;
  assign cur_b      = in_post ? bpost_q : bpre_q;
  assign last_pre   = (idx_q == IW'(F - 1));
  assign last_post  = (idx_q == IW'(N - 1));

  always_comb begin
    cur_t     = '0;
    cur_spike = 1'b0;
    if (in_post) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IW'(i)) begin
          cur_t     = y_q[i];
          cur_spike = post_q[i];
        end
      end
    end else begin
      for (int i = 0; i < F; i++) begin
        if (idx_q == IW'(i)) begin
          cur_t     = x_q[i];
          cur_spike = pre_q[i];
        end
      end
    end
  end

  // Out-of-range indices match nothing and read back as zero.
  always_comb begin
    rd_sel = '0;
    if (rd_is_post) begin
      for (int i = 0; i < N; i++) if (rd_idx == IW'(i)) rd_sel = y_q[i];
    end else begin
      for (int i = 0; i < F; i++) if (rd_idx == IW'(i)) rd_sel = x_q[i];
    end
  end

  trace_decay_q14 #(.Q(Q)) u_decay (
    .t      (cur_t),
    .lambda (cur_lambda),
    .b      (cur_b),
    .spike  (cur_spike),
    .result (upd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      lx_q        <= '0;
      ly_q        <= '0;
      bpre_q      <= '0;
      bpost_q     <= '0;
      step_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      for (int i = 0; i < F; i++) x_q[i] <= '0;
      for (int i = 0; i < N; i++) y_q[i] <= '0;
    end else begin
      rd_valid_q  <= rd_en;
      if (rd_en) rd_data_q <= rd_sel;
      step_done_q <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        idx_q   <= '0;
        for (int i = 0; i < F; i++) x_q[i] <= '0;
        for (int i = 0; i < N; i++) y_q[i] <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (step_valid) begin
              pre_q   <= pre_bits;
              post_q  <= post_bits;
              lx_q    <= lambda_x;
              ly_q    <= lambda_y;
              bpre_q  <= b_pre;
              bpost_q <= b_post;
              idx_q   <= '0;
              state_q <= StPre;
            end
          end
          StPre: begin
            for (int i = 0; i < F; i++) if (idx_q == IW'(i)) x_q[i] <= upd;
            if (last_pre) begin
              idx_q   <= '0;
              state_q <= StPost;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StPost: begin
            for (int i = 0; i < N; i++) if (idx_q == IW'(i)) y_q[i] <= upd;
            if (last_post) begin
              idx_q       <= '0;
              state_q     <= StDone;
              step_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign step_ready = (state_q == StIdle);
  assign step_done  = step_done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_stdp_trace_q14.sv
// Directed bench for stdp_trace_q14 with F=4, N=3 and hand-computed trace values.
module tb_stdp_trace_q14;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               step_valid;
  logic               step_ready;
  logic [3:0]         pre_bits;
  logic [2:0]         post_bits;
  logic signed [15:0] lambda_x, lambda_y, b_pre, b_post;
  logic               clear;
  logic               step_done;
  logic               rd_en;
  logic               rd_is_post;
  logic [1:0]         rd_idx;
  logic signed [15:0] rd_data;
  logic               rd_valid;

  int total = 0;
  int bad   = 0;

  stdp_trace_q14 #(.F(4), .N(3), .Q(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .pre_bits   (pre_bits),
    .post_bits  (post_bits),
    .lambda_x   (lambda_x),
    .lambda_y   (lambda_y),
    .b_pre      (b_pre),
    .b_post     (b_post),
    .clear      (clear),
    .step_done  (step_done),
    .rd_en      (rd_en),
    .rd_is_post (rd_is_post),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept a step, then scramble the inputs so only latched values can be used.
  task automatic start_step(input logic signed [15:0] lx, input logic signed [15:0] ly,
                            input logic signed [15:0] bp, input logic signed [15:0] bq,
                            input logic [3:0] pre, input logic [2:0] post);
    lambda_x   = lx;
    lambda_y   = ly;
    b_pre      = bp;
    b_post     = bq;
    pre_bits   = pre;
    post_bits  = post;
    step_valid = 1'b1;
    tick;
    step_valid = 1'b0;
    lambda_x   = '0;
    lambda_y   = '0;
    b_pre      = 16'sd7777;
    b_post     = 16'sd7777;
    pre_bits   = '1;
    post_bits  = '1;
  endtask

  task automatic finish_step(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (step_done) seen = 1'b1;
      tick;
    end
    check(tag, 32'(seen), 1);
  endtask

  task automatic run_step(input logic signed [15:0] lx, input logic signed [15:0] ly,
                          input logic signed [15:0] bp, input logic signed [15:0] bq,
                          input logic [3:0] pre, input logic [2:0] post);
    start_step(lx, ly, bp, bq, pre, post);
    finish_step("step_done");
  endtask

  task automatic rd_chk(input string tag, input logic post, input logic [1:0] idx,
                        input int exp);
    rd_en      = 1'b1;
    rd_is_post = post;
    rd_idx     = idx;
    tick;
    rd_en = 1'b0;
    check(tag, 32'(rd_data), exp);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; step_valid = 1'b0; clear = 1'b0;
    pre_bits = '0; post_bits = '0;
    lambda_x = '0; lambda_y = '0; b_pre = '0; b_post = '0;
    rd_en = 1'b0; rd_is_post = 1'b0; rd_idx = '0;
    tick;
    tick;
    check("rst_ready", 32'(step_ready), 1);
    check("rst_done", 32'(step_done), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    tick;

    // Sweep timing: busy for cycles 1..8, done only in cycle 8.
    start_step(16384, 16384, 1000, 0, 4'b0101, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      check("busy_ready", 32'(step_ready), 0);
      check("done_pulse", 32'(step_done), (k == 8) ? 1 : 0);
      tick;
    end
    check("idle_ready", 32'(step_ready), 1);
    check("idle_done", 32'(step_done), 0);
    rd_chk("x0_a", 1'b0, 2'd0, 1000);
    rd_chk("x1_a", 1'b0, 2'd1, 0);
    rd_chk("x2_a", 1'b0, 2'd2, 1000);
    rd_chk("x3_a", 1'b0, 2'd3, 0);

    // Second identical step; a read of x[0] on its update edge sees the old value.
    start_step(16384, 16384, 1000, 0, 4'b0101, 3'b000);
    rd_chk("rbw_x0", 1'b0, 2'd0, 1000);
    finish_step("step2_done");
    rd_chk("x2_b", 1'b0, 2'd2, 2000);
    check("rd_valid_hi", 32'(rd_valid), 1);
    tick;
    check("rd_valid_lo", 32'(rd_valid), 0);
    rd_chk("x0_b", 1'b0, 2'd0, 2000);

    // Decay and floor: x = {1,0,1000,0} -> halve -> {0,0,500,0}; negate -> clamp.
    run_step(0, 16384, 1, 0, 4'b0001, 3'b000);
    rd_chk("x0_one", 1'b0, 2'd0, 1);
    run_step(16384, 16384, 1000, 0, 4'b0100, 3'b000);
    run_step(8192, 16384, 0, 0, 4'b0000, 3'b000);
    rd_chk("x0_floor", 1'b0, 2'd0, 0);
    rd_chk("x2_half", 1'b0, 2'd2, 500);
    run_step(-16384, 16384, 0, 0, 4'b0000, 3'b000);
    rd_chk("x2_negclamp", 1'b0, 2'd2, 0);
    // 3 * -0.5 floors to -2, plus bump 5 gives 3.
    run_step(0, 16384, 3, 0, 4'b0001, 3'b000);
    run_step(-8192, 16384, 5, 0, 4'b0001, 3'b000);
    rd_chk("x0_negfloor", 1'b0, 2'd0, 3);

    // Post traces: saturation and negative bump.
    run_step(16384, 0, 0, 1000, 4'b0000, 3'b011);
    rd_chk("y0_init", 1'b1, 2'd0, 1000);
    run_step(16384, 16384, 0, 29000, 4'b0000, 3'b010);
    rd_chk("y1_30000", 1'b1, 2'd1, 30000);
    run_step(16384, 16384, 0, 5000, 4'b0000, 3'b010);
    rd_chk("y1_sat", 1'b1, 2'd1, 32767);
    run_step(16384, 16384, 0, -2000, 4'b0000, 3'b001);
    rd_chk("y0_negbump", 1'b1, 2'd0, 0);
    rd_chk("y1_hold", 1'b1, 2'd1, 32767);
    rd_chk("y2_zero", 1'b1, 2'd2, 0);
    rd_chk("y_oob", 1'b1, 2'd3, 0);
    rd_chk("x0_kept", 1'b0, 2'd0, 3);

    // Clear at cycle 3 of a sweep aborts it without step_done.
    start_step(16384, 16384, 100, 100, 4'b1111, 3'b111);
    tick;
    tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clr_ready", 32'(step_ready), 1);
    check("clr_done", 32'(step_done), 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (step_done) cnt++;
      tick;
    end
    check("clr_no_done", cnt, 0);
    for (int i = 0; i < 4; i++) rd_chk("clr_x", 1'b0, 2'(i), 0);
    for (int i = 0; i < 3; i++) rd_chk("clr_y", 1'b1, 2'(i), 0);

    // Clear together with step_valid in idle: step is dropped.
    lambda_x = 16384; lambda_y = 16384; b_pre = 100; b_post = 100;
    pre_bits = '1; post_bits = '1;
    clear = 1'b1; step_valid = 1'b1;
    tick;
    clear = 1'b0; step_valid = 1'b0;
    check("clrv_ready", 32'(step_ready), 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (!step_ready || step_done) cnt++;
      tick;
    end
    check("clrv_not_accepted", cnt, 0);
    rd_chk("clrv_x0", 1'b0, 2'd0, 0);

    // Reset in the middle of a sweep.
    run_step(16384, 16384, 500, 0, 4'b0001, 3'b000);
    rd_chk("x0_pre_rst", 1'b0, 2'd0, 500);
    start_step(16384, 16384, 500, 0, 4'b0001, 3'b000);
    tick;
    rd_en = 1'b1; rd_is_post = 1'b0; rd_idx = 2'd0;
    rst_n = 1'b0;
    tick;
    rd_en = 1'b0;
    rst_n = 1'b1;
    check("mrst_ready", 32'(step_ready), 1);
    check("mrst_done", 32'(step_done), 0);
    check("mrst_rd_valid", 32'(rd_valid), 0);
    check("mrst_rd_data", 32'(rd_data), 0);
    rd_chk("mrst_x0", 1'b0, 2'd0, 0);
    rd_chk("mrst_oob", 1'b1, 2'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
